// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - shared KGP_RISC fetch/decode types and constants
package kgp_pkg;

  localparam int PC_INC     = 4;
  localparam int INST_W     = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 29;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    FLUSH
  } fetch_state_e;

  // Opcode extraction shared with the decoder so field positions live in one place
  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] get_opcode(input logic [INST_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch stage bus: imem request/response, decoder handshake, redirect
interface inst_fetch_if
  import kgp_pkg::*;
#(
  parameter int PC_W = 32
) ();

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_valid;
  logic              dec_ready;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input  imem_rvalid, imem_rdata, dec_ready, redirect, redirect_pc
  );

  // Memory / decoder / redirect source side
  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_rvalid, imem_rdata, dec_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - KGP_RISC instruction fetch: PC, single-outstanding imem fetch, decoder handoff
module inst_fetch
  import kgp_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
  logic              valid_q, valid_d;
  // Low for the first cycle after reset so imem_req stays low during reset
  // and the first request appears one edge after release.
  logic              run_q;
  logic [PC_W-1:0]   redir_pc;

  assign redir_pc = bus.redirect_pc & ~PC_W'(3);

  // State, PC and instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      run_q     <= 1'b1;
    end
  end

  // Next-state and datapath updates; redirect overrides pc and valid in every state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;

    if (run_q) begin
      case (state_q)
        FETCH: begin
          // A request is on the bus this cycle; a redirect makes it stale
          state_d = bus.redirect ? FLUSH : WAIT;
        end
        WAIT: begin
          if (bus.redirect) begin
            state_d = bus.imem_rvalid ? FETCH : FLUSH;
          end else if (bus.imem_rvalid) begin
            inst_d    = bus.imem_rdata;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + PC_W'(PC_INC);
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (bus.redirect || bus.dec_ready) begin
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
        FLUSH: begin
          if (bus.imem_rvalid) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end

    if (bus.redirect) begin
      pc_d    = redir_pc;
      valid_d = 1'b0;
    end
  end

  assign bus.imem_req   = run_q && (state_q == FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = valid_q;

endmodule
